// File: rtl/qupls_dest_rename_pkg.sv
// qupls_dest_rename_pkg: shared types and sizes for destination renaming
package qupls_dest_rename_pkg;
    localparam int NAREG = 64;
    localparam int NPREG = 256;
    localparam int AW = $clog2(NAREG);
    localparam int PW = $clog2(NPREG);
    typedef logic [7:0] pregno_t;
    typedef logic [8:0] aregno_t;
    typedef logic [PW-1:0] ptr_t;
    typedef struct packed {
        pregno_t pRt;
        pregno_t pRt_old;
        logic    Rtz;
    } rename_rec_t;
endpackage

// File: rtl/qupls_free_fifo.sv
// qupls_free_fifo: circular physical-register free list with speculative and committed heads
module qupls_free_fifo import qupls_dest_rename_pkg::*; (
    input  logic       clk,
    input  logic       rst,
    input  logic       pop,
    input  logic       push,
    input  pregno_t    push_preg,
    input  logic       adv,
    input  logic       restore,
    output pregno_t    pop_preg,
    output logic [8:0] count
);
    pregno_t fl [NPREG];
    ptr_t head, chead, tail, chead_nxt;

    assign chead_nxt = chead + PW'(adv);
    assign pop_preg  = fl[head];
    assign count     = {1'b0, tail - head};

    // Storage: preloaded with every physical register not used by the identity map
    always_ff @(posedge clk or posedge rst)
        if (rst)
            for (int i = 0; i < NPREG; i++)
                fl[i] <= (i < NPREG - NAREG) ? pregno_t'(NAREG + i) : '0;
        else if (push)
            fl[tail] <= push_preg;

    // Pointers: restore rolls head back to the post-commit committed head; tail never rolls back
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            head  <= '0;
            chead <= '0;
            tail  <= PW'(NPREG - NAREG);
        end else begin
            chead <= chead_nxt;
            tail  <= tail + PW'(push);
            head  <= restore ? chead_nxt : head + PW'(pop);
        end
endmodule

// File: rtl/qupls_dest_rename.sv
// qupls_dest_rename: allocates physical destinations and keeps speculative/committed maps
module qupls_dest_rename import qupls_dest_rename_pkg::*; (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       in_v,
    output logic       in_rdy,
    input  logic [8:0] in_Rt,
    input  logic       in_Rtz,
    output logic       out_v,
    input  logic       out_rdy,
    output logic [7:0] out_pRt,
    output logic [7:0] out_pRt_old,
    output logic       out_Rtz,
    output logic       out_err,
    input  logic       cmt_v,
    input  logic       cmt_Rtz,
    input  logic [8:0] cmt_aRt,
    input  logic [7:0] cmt_pRt,
    input  logic [7:0] cmt_pRt_old,
    output logic [8:0] free_count
);
    pregno_t rat [NAREG];
    pregno_t crat [NAREG];
    pregno_t crat_nxt [NAREG];
    pregno_t head_preg;
    rename_rec_t rec;
    logic legal, has_dest, xfer, pop, cmt_dst, cmt_wr;
    logic [AW-1:0] ridx, cidx;

    assign legal    = in_Rt < 9'(NAREG);
    assign has_dest = ~in_Rtz & legal & (in_Rt != '0);
    assign in_rdy   = ~flush & (~out_v | out_rdy) & (free_count != '0);
    assign xfer     = in_v & in_rdy;
    assign pop      = xfer & has_dest;
    assign ridx     = in_Rt[AW-1:0];
    assign cidx     = cmt_aRt[AW-1:0];
    assign cmt_dst  = cmt_v & ~cmt_Rtz;
    assign cmt_wr   = cmt_dst & (cmt_aRt < 9'(NAREG)) & (cmt_aRt != '0);

    assign out_pRt     = rec.pRt;
    assign out_pRt_old = rec.pRt_old;
    assign out_Rtz     = rec.Rtz;

    // Committed map as it stands after this cycle's commit, also the flush source
    always_comb
        for (int i = 0; i < NAREG; i++)
            crat_nxt[i] = (cmt_wr && cidx == AW'(i)) ? cmt_pRt : crat[i];

    // Committed map register
    always_ff @(posedge clk or posedge rst)
        if (rst)
            for (int i = 0; i < NAREG; i++)
                crat[i] <= pregno_t'(i);
        else
            for (int i = 0; i < NAREG; i++)
                crat[i] <= crat_nxt[i];

    // Speculative map: bulk restore on flush, single-entry update on allocation
    always_ff @(posedge clk or posedge rst)
        if (rst)
            for (int i = 0; i < NAREG; i++)
                rat[i] <= pregno_t'(i);
        else if (flush)
            for (int i = 0; i < NAREG; i++)
                rat[i] <= crat_nxt[i];
        else if (pop)
            rat[ridx] <= head_preg;

    // Output register: loads on transfer, holds while stalled, drops on flush
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            out_v   <= 1'b0;
            rec     <= '{pRt: '0, pRt_old: '0, Rtz: 1'b1};
            out_err <= 1'b0;
        end else if (flush)
            out_v <= 1'b0;
        else if (xfer) begin
            out_v   <= 1'b1;
            rec     <= '{pRt: has_dest ? head_preg : '0, pRt_old: has_dest ? rat[ridx] : '0, Rtz: ~has_dest};
            out_err <= ~legal;
        end else if (out_rdy)
            out_v <= 1'b0;

    qupls_free_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .pop       (pop),
        .push      (cmt_dst & (cmt_pRt_old != '0)),
        .push_preg (cmt_pRt_old),
        .adv       (cmt_dst),
        .restore   (flush),
        .pop_preg  (head_preg),
        .count     (free_count)
    );
endmodule

// File: doc/qupls_dest_rename.md
Name: qupls_dest_rename

Overview:
- Destination-register rename stage that sits directly downstream of the decoder's target-register select.
- Consumes the already mode-banked architectural target (aregno_t) and its zero flag.
- Allocates a physical register from a circular free list and returns the previous mapping for later release.
- Keeps a speculative map (RAT) and a committed map (CRAT), plus speculative and committed free-list head pointers, so a flush restores state in one cycle.

Parameters:
- NAREG, 64, number of architectural registers mapped; aregno_t values >= NAREG are illegal.
- NPREG, 256, number of physical registers; free-list storage depth is NPREG entries.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  pipeline flush (branch miss or exception); restores the committed state
- in_v  in  1  decoded instruction valid
- in_rdy  out  1  stage can accept this cycle
- in_Rt  in  9  architectural target (aregno_t), already banked
- in_Rtz  in  1  no destination
- out_v  out  1  renamed result valid
- out_rdy  in  1  downstream accepts
- out_pRt  out  8  allocated physical target (pregno_t)
- out_pRt_old  out  8  previous mapping of the architectural register
- out_Rtz  out  1  no destination (passed through; also set for illegal Rt)
- out_err  out  1  in_Rt >= NAREG was seen
- cmt_v  in  1  in-order commit of one instruction
- cmt_Rtz  in  1  committed instruction has no destination
- cmt_aRt  in  9  committed architectural target
- cmt_pRt  in  8  committed physical target
- cmt_pRt_old  in  8  mapping released at commit
- free_count  out  9  free-list occupancy

Behaviour:
- Reset, applied asynchronously:
  - RAT[i] = CRAT[i] = i.
  - Free list holds NAREG..NPREG-1 at slots 0..NPREG-NAREG-1.
  - head = chead = 0; tail = NPREG-NAREG; free_count = NPREG-NAREG.
  - out_v = 0, out_pRt = 0, out_pRt_old = 0, out_Rtz = 1, out_err = 0.
- Architectural register 0 and physical register 0 are hardwired. in_Rt==0 is treated as Rtz, and RAT[0] is never written.
- Accept condition:
  - in_rdy = ~flush & (~out_v | out_rdy) & (free_count != 0).
  - free_count is the registered value. A release in the same cycle does not bypass into an empty list.
  - A transfer happens when in_v & in_rdy.
- Transfer with a destination (Rtz=0, in_Rt<NAREG):
  - out_pRt = fl[head]; out_pRt_old = RAT[in_Rt].
  - RAT[in_Rt] <= fl[head]; head++ (wraps mod NPREG).
  - Outputs are registered: one cycle latency, out_v is set the next cycle.
- Transfer with no destination (Rtz, in_Rt==0, or in_Rt>=NAREG):
  - No allocation; out_pRt = out_pRt_old = 0; out_Rtz = 1.
  - out_err = 1 only for the in_Rt>=NAREG case.
- Output hold: while out_v & ~out_rdy, all outputs hold steady.
- Commit, when cmt_v & ~cmt_Rtz:
  - CRAT[cmt_aRt] <= cmt_pRt; chead++.
  - fl[tail] <= cmt_pRt_old; tail++.
  - Commits are in program order, so chead tracks head.
  - cmt_pRt_old==0 is never pushed; chead still advances.
- free_count = tail - head, modulo NPREG, as a 9-bit count. A simultaneous allocate and release leaves the count unchanged. It never exceeds NPREG-NAREG+1.
- Flush:
  - Takes priority over accept; out_v <= 0.
  - Same-cycle commit is applied first, then RAT <= CRAT (post-commit) and head <= chead (post-commit).
  - tail is never rolled back.
- Reset mid-operation: asynchronous return to the reset state regardless of in_v or cmt_v.
- Pointers are log2(NPREG) bits wide and wrap naturally.

Decomposition:
- QuplsPkg holds:
  - pregno_t (8-bit);
  - the NAREG and NPREG constants;
  - an in-flight rename record struct {pRt, pRt_old, Rtz}.
- One sub-module, qupls_free_fifo: circular storage plus head, chead and tail, with pop, push and restore ports and the count output.
- RAT and CRAT stay in the top level as flop arrays, giving single-cycle bulk copy.

Test Plan:
- Reset, then in_Rt=5 with in_v, out_rdy=1 -> next cycle out_pRt=64, out_pRt_old=5, free_count=191.
- Rename in_Rt=5 twice back-to-back -> second result out_pRt=65, out_pRt_old=64.
- in_Rtz=1, then in_Rt=0, then in_Rt=70 -> out_Rtz=1 and out_pRt=0 each time; out_err=1 only on the 70 case; free_count unchanged.
- Allocate 192 times without commit -> free_count=0 and in_rdy=0. Apply cmt_v with cmt_pRt_old=5 -> next cycle free_count=1 and in_rdy=1.
- Rename r5->64 and r6->65, commit only r5, then flush -> RAT[6]=6, RAT[5]=64, head=chead=1. The next r7 rename gets out_pRt=65.
- Hold out_rdy=0 with in_v=1 for 3 cycles -> outputs stable, in_rdy=0, no head advance. Assert rst mid-stall -> all outputs at reset values immediately.
